// File: rtl/adder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : adder_pkg
// Purpose  : Shared state encoding and sizing helper for the serial adder.
// Revision : 1.0
// ============================================================================
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

    // Counter needs at least one bit even when only one digit is processed.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/full_adder.sv
`default_nettype none
// ============================================================================
// Module   : full_adder
// Purpose  : Single-bit full adder cell.
// Revision : 1.0
// ============================================================================
module full_adder (
    input  logic x,
    input  logic y,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = x ^ y ^ cin;
    assign cout = (x & y) | (cin & (x ^ y));

endmodule
`default_nettype wire

// File: rtl/serial_adder_digit_adder.sv
`default_nettype none
// ============================================================================
// Module   : digit_adder
// Purpose  : Combinational DIGIT-bit ripple adder built from full_adder cells.
// Revision : 1.0
// ============================================================================
module digit_adder #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             cin,
    output logic [DIGIT-1:0] sum,
    output logic             cout,
    output logic             c_msb
);

    logic [DIGIT:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < DIGIT; i++) begin : g_fa
        full_adder u_fa (
            .x    (x[i]),
            .y    (y[i]),
            .cin  (c[i]),
            .sum  (sum[i]),
            .cout (c[i+1])
        );
    end

    assign cout  = c[DIGIT];
    // Carry into the top bit; XOR with cout yields signed overflow.
    assign c_msb = c[DIGIT-1];

endmodule
`default_nettype wire

// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
// Module   : serial_adder
// Purpose  : Multi-cycle adder/subtractor, DIGIT bits per clock, LSB first.
// Revision : 1.0
// ============================================================================
module serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             n_reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             ov,
    output logic             zero
);

    localparam int N     = WIDTH / DIGIT;
    localparam int CNT_W = cnt_width(N);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_param
        $error("serial_adder: WIDTH must be a positive multiple of DIGIT");
    end

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic [WIDTH-1:0]   s_q, s_d;
    logic               co_q, co_d;
    logic               ov_q, ov_d;
    logic               zero_q, zero_d;

    logic               accept;
    logic [DIGIT-1:0]   dig_a, dig_b, dig_sum;
    logic               dig_cout, dig_cmsb;

    assign accept = start && (state_q == IDLE || state_q == DONE);
    assign dig_a  = a_q[int'(cnt_q)*DIGIT +: DIGIT];
    assign dig_b  = b_q[int'(cnt_q)*DIGIT +: DIGIT];

    digit_adder #(.DIGIT(DIGIT)) u_digit (
        .x     (dig_a),
        .y     (dig_b),
        .cin   (carry_q),
        .sum   (dig_sum),
        .cout  (dig_cout),
        .c_msb (dig_cmsb)
    );

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (cnt_q == LAST) state_d = DONE;
            DONE:    state_d = start ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == RUN);
        done = (state_q == DONE);
    end

    // Subtraction is a + ~b + ~ci; inversion happens once at capture.
    always_comb begin
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        res_d   = res_q;
        s_d     = s_q;
        co_d    = co_q;
        ov_d    = ov_q;
        zero_d  = zero_q;
        if (accept) begin
            a_d     = a;
            b_d     = b ^ {WIDTH{sub}};
            carry_d = ci ^ sub;
            cnt_d   = '0;
            res_d   = '0;
        end else if (state_q == RUN) begin
            res_d[int'(cnt_q)*DIGIT +: DIGIT] = dig_sum;
            carry_d = dig_cout;
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == LAST) begin
                cnt_d  = '0;
                s_d    = res_d;
                co_d   = dig_cout;
                ov_d   = dig_cmsb ^ dig_cout;
                zero_d = (res_d == '0);
            end
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            res_q   <= '0;
            s_q     <= '0;
            co_q    <= 1'b0;
            ov_q    <= 1'b0;
            zero_q  <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            res_q   <= res_d;
            s_q     <= s_d;
            co_q    <= co_d;
            ov_q    <= ov_d;
            zero_q  <= zero_d;
        end
    end

    assign s    = s_q;
    assign co   = co_q;
    assign ov   = ov_q;
    assign zero = zero_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_adder
// Purpose  : Directed and exhaustive self-checking bench for serial_adder.
// Revision : 1.0
// ============================================================================
module tb_serial_adder;

    logic clk = 1'b0;
    logic n_reset;
    always #5 clk = ~clk;

    logic [15:0] a16, b16;
    logic        ci16, sub16;
    logic        st1, st4, st2;
    logic        busy1, done1, co1, ov1, z1;
    logic        busy4, done4, co4, ov4, z4;
    logic        busy2, done2, co2, ov2, z2;
    logic [15:0] s1, s4, s2;

    logic [3:0]  a4, b4;
    logic        ci4, sub4, stw;
    logic        bw1, dw1, cw1, ow1, zw1;
    logic        bw2, dw2, cw2, ow2, zw2;
    logic        bw4, dw4, cw4, ow4, zw4;
    logic [3:0]  sw1, sw2, sw4;

    int errors = 0;
    int checks = 0;

    serial_adder #(.WIDTH(16), .DIGIT(1)) u16d1 (
        .clk(clk), .n_reset(n_reset), .start(st1), .a(a16), .b(b16), .ci(ci16), .sub(sub16),
        .busy(busy1), .done(done1), .s(s1), .co(co1), .ov(ov1), .zero(z1));
    serial_adder #(.WIDTH(16), .DIGIT(4)) u16d4 (
        .clk(clk), .n_reset(n_reset), .start(st4), .a(a16), .b(b16), .ci(ci16), .sub(sub16),
        .busy(busy4), .done(done4), .s(s4), .co(co4), .ov(ov4), .zero(z4));
    serial_adder #(.WIDTH(16), .DIGIT(2)) u16d2 (
        .clk(clk), .n_reset(n_reset), .start(st2), .a(a16), .b(b16), .ci(ci16), .sub(sub16),
        .busy(busy2), .done(done2), .s(s2), .co(co2), .ov(ov2), .zero(z2));
    serial_adder #(.WIDTH(4), .DIGIT(1)) u4d1 (
        .clk(clk), .n_reset(n_reset), .start(stw), .a(a4), .b(b4), .ci(ci4), .sub(sub4),
        .busy(bw1), .done(dw1), .s(sw1), .co(cw1), .ov(ow1), .zero(zw1));
    serial_adder #(.WIDTH(4), .DIGIT(2)) u4d2 (
        .clk(clk), .n_reset(n_reset), .start(stw), .a(a4), .b(b4), .ci(ci4), .sub(sub4),
        .busy(bw2), .done(dw2), .s(sw2), .co(cw2), .ov(ow2), .zero(zw2));
    serial_adder #(.WIDTH(4), .DIGIT(4)) u4d4 (
        .clk(clk), .n_reset(n_reset), .start(stw), .a(a4), .b(b4), .ci(ci4), .sub(sub4),
        .busy(bw4), .done(dw4), .s(sw4), .co(cw4), .ov(ow4), .zero(zw4));

    // Pulses start on one 16-bit instance and waits for its done; lat is the
    // negedge index (1 = first after the accepting edge) where done was seen.
    task automatic op16(input int inst, input logic [15:0] av, input logic [15:0] bv,
                        input logic civ, input logic subv, output int lat, output int bcnt);
        logic d, bb;
        a16 = av; b16 = bv; ci16 = civ; sub16 = subv;
        case (inst)
            1:       st1 = 1'b1;
            4:       st4 = 1'b1;
            default: st2 = 1'b1;
        endcase
        lat = 0;
        bcnt = 0;
        @(negedge clk);
        st1 = 1'b0; st4 = 1'b0; st2 = 1'b0;
        for (int k = 1; k <= 64; k++) begin
            d  = (inst == 1) ? done1 : (inst == 4) ? done4 : done2;
            bb = (inst == 1) ? busy1 : (inst == 4) ? busy4 : busy2;
            if (d) begin
                lat = k;
                break;
            end
            if (bb) bcnt++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        n_reset = 1'b0;
        st1 = 0; st4 = 0; st2 = 0; stw = 0;
        a16 = '0; b16 = '0; ci16 = 0; sub16 = 0;
        a4 = '0; b4 = '0; ci4 = 0; sub4 = 0;
        #12;
        checks++; if (s1 !== 16'h0000) begin errors++; $display("FAIL reset_s got=%h exp=0000", s1); end
        checks++; if (co1 !== 1'b0) begin errors++; $display("FAIL reset_co got=%b exp=0", co1); end
        checks++; if (ov1 !== 1'b0) begin errors++; $display("FAIL reset_ov got=%b exp=0", ov1); end
        checks++; if (z1 !== 1'b1) begin errors++; $display("FAIL reset_zero got=%b exp=1", z1); end
        checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy1); end
        checks++; if (done1 !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done1); end
        checks++; if (zw4 !== 1'b1) begin errors++; $display("FAIL reset_zero_w4 got=%b exp=1", zw4); end
        @(negedge clk);
        n_reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_bit_serial_add;
        int lat, bc;
        op16(1, 16'h1234, 16'h0FFF, 1'b0, 1'b0, lat, bc);
        checks++; if (lat !== 17) begin errors++; $display("FAIL d1_latency got=%0d exp=17", lat); end
        checks++; if (bc !== 16) begin errors++; $display("FAIL d1_busy_cycles got=%0d exp=16", bc); end
        checks++; if (s1 !== 16'h2233) begin errors++; $display("FAIL d1_s got=%h exp=2233", s1); end
        checks++; if (co1 !== 1'b0) begin errors++; $display("FAIL d1_co got=%b exp=0", co1); end
        checks++; if (ov1 !== 1'b0) begin errors++; $display("FAIL d1_ov got=%b exp=0", ov1); end
        checks++; if (z1 !== 1'b0) begin errors++; $display("FAIL d1_zero got=%b exp=0", z1); end
        checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL d1_busy_at_done got=%b exp=0", busy1); end
    endtask

    task automatic test_digit4_flags;
        int lat, bc;
        op16(4, 16'h7FFF, 16'h0001, 1'b0, 1'b0, lat, bc);
        checks++; if (lat !== 5) begin errors++; $display("FAIL d4_latency got=%0d exp=5", lat); end
        checks++; if (bc !== 4) begin errors++; $display("FAIL d4_busy_cycles got=%0d exp=4", bc); end
        checks++; if (s4 !== 16'h8000) begin errors++; $display("FAIL d4_ovf_s got=%h exp=8000", s4); end
        checks++; if (ov4 !== 1'b1) begin errors++; $display("FAIL d4_ovf_ov got=%b exp=1", ov4); end
        checks++; if (co4 !== 1'b0) begin errors++; $display("FAIL d4_ovf_co got=%b exp=0", co4); end
        checks++; if (z4 !== 1'b0) begin errors++; $display("FAIL d4_ovf_zero got=%b exp=0", z4); end
        op16(4, 16'hFFFF, 16'h0001, 1'b0, 1'b0, lat, bc);
        checks++; if (s4 !== 16'h0000) begin errors++; $display("FAIL d4_wrap_s got=%h exp=0000", s4); end
        checks++; if (co4 !== 1'b1) begin errors++; $display("FAIL d4_wrap_co got=%b exp=1", co4); end
        checks++; if (z4 !== 1'b1) begin errors++; $display("FAIL d4_wrap_zero got=%b exp=1", z4); end
        checks++; if (ov4 !== 1'b0) begin errors++; $display("FAIL d4_wrap_ov got=%b exp=0", ov4); end
    endtask

    task automatic test_subtract;
        int lat, bc;
        op16(2, 16'd5, 16'd7, 1'b0, 1'b1, lat, bc);
        checks++; if (lat !== 9) begin errors++; $display("FAIL d2_latency got=%0d exp=9", lat); end
        checks++; if (s2 !== 16'hFFFE) begin errors++; $display("FAIL sub_5m7_s got=%h exp=fffe", s2); end
        checks++; if (co2 !== 1'b0) begin errors++; $display("FAIL sub_5m7_co got=%b exp=0", co2); end
        checks++; if (ov2 !== 1'b0) begin errors++; $display("FAIL sub_5m7_ov got=%b exp=0", ov2); end
        op16(2, 16'd7, 16'd5, 1'b1, 1'b1, lat, bc);
        checks++; if (s2 !== 16'h0001) begin errors++; $display("FAIL sub_7m5m1_s got=%h exp=0001", s2); end
        checks++; if (co2 !== 1'b1) begin errors++; $display("FAIL sub_7m5m1_co got=%b exp=1", co2); end
        checks++; if (z2 !== 1'b0) begin errors++; $display("FAIL sub_7m5m1_zero got=%b exp=0", z2); end
    endtask

    task automatic test_back_to_back;
        int lat, bc, lat2;
        a16 = 16'h0100; b16 = 16'h0011; ci16 = 0; sub16 = 0;
        st4 = 1'b1;
        @(negedge clk);
        a16 = 16'hAAAA; b16 = 16'h1111;
        lat = 0; bc = 0;
        for (int k = 1; k <= 20; k++) begin
            if (done4) begin lat = k; break; end
            if (busy4) bc++;
            @(negedge clk);
        end
        checks++; if (lat !== 5) begin errors++; $display("FAIL hs_latency got=%0d exp=5", lat); end
        checks++; if (bc !== 4) begin errors++; $display("FAIL hs_busy_cycles got=%0d exp=4", bc); end
        checks++; if (s4 !== 16'h0111) begin errors++; $display("FAIL hs_first_s got=%h exp=0111", s4); end
        checks++; if (busy4 !== 1'b0) begin errors++; $display("FAIL hs_busy_in_done got=%b exp=0", busy4); end
        @(negedge clk);
        st4 = 1'b0;
        checks++; if (busy4 !== 1'b1) begin errors++; $display("FAIL hs_restart_busy got=%b exp=1", busy4); end
        checks++; if (done4 !== 1'b0) begin errors++; $display("FAIL hs_restart_done got=%b exp=0", done4); end
        checks++; if (s4 !== 16'h0111) begin errors++; $display("FAIL hs_s_held got=%h exp=0111", s4); end
        lat2 = 0;
        for (int k = 6; k <= 30; k++) begin
            if (done4) begin lat2 = k; break; end
            @(negedge clk);
        end
        checks++; if (lat2 !== 10) begin errors++; $display("FAIL hs_second_latency got=%0d exp=10", lat2); end
        checks++; if (s4 !== 16'hBBBB) begin errors++; $display("FAIL hs_second_s got=%h exp=bbbb", s4); end
    endtask

    task automatic test_reset_midop;
        int lat, bc;
        a16 = 16'h00FF; b16 = 16'h00FF; ci16 = 0; sub16 = 0;
        st1 = 1'b1;
        @(negedge clk);
        st1 = 1'b0;
        repeat (5) @(negedge clk);
        checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL rst_mid_busy_before got=%b exp=1", busy1); end
        #2 n_reset = 1'b0;
        #1;
        checks++; if (s1 !== 16'h0000) begin errors++; $display("FAIL rst_mid_s got=%h exp=0000", s1); end
        checks++; if (z1 !== 1'b1) begin errors++; $display("FAIL rst_mid_zero got=%b exp=1", z1); end
        checks++; if (co1 !== 1'b0) begin errors++; $display("FAIL rst_mid_co got=%b exp=0", co1); end
        checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got=%b exp=0", busy1); end
        checks++; if (done1 !== 1'b0) begin errors++; $display("FAIL rst_mid_done got=%b exp=0", done1); end
        @(negedge clk);
        n_reset = 1'b1;
        @(negedge clk);
        op16(1, 16'd1, 16'd1, 1'b0, 1'b0, lat, bc);
        checks++; if (lat !== 17) begin errors++; $display("FAIL rst_after_latency got=%0d exp=17", lat); end
        checks++; if (s1 !== 16'd2) begin errors++; $display("FAIL rst_after_s got=%h exp=0002", s1); end
        checks++; if (z1 !== 1'b0) begin errors++; $display("FAIL rst_after_zero got=%b exp=0", z1); end
    endtask

    task automatic test_exhaustive_w4;
        int g1, g2, g4, r, rs, sa, sb;
        logic [3:0] es;
        logic ec, eo, ez;
        for (int sv = 0; sv < 2; sv++)
        for (int cv = 0; cv < 2; cv++)
        for (int av = 0; av < 16; av++)
        for (int bv = 0; bv < 16; bv++) begin
            a4 = 4'(av); b4 = 4'(bv); ci4 = cv[0]; sub4 = sv[0];
            stw = 1'b1;
            @(negedge clk);
            stw = 1'b0;
            g1 = 0; g2 = 0; g4 = 0;
            for (int k = 1; k <= 12 && g1 == 0; k++) begin
                if (dw4 && g4 == 0) g4 = k;
                if (dw2 && g2 == 0) g2 = k;
                if (dw1) g1 = k;
                if (g1 == 0) @(negedge clk);
            end
            sa = (av >= 8) ? av - 16 : av;
            sb = (bv >= 8) ? bv - 16 : bv;
            if (sv == 0) begin
                r = av + bv + cv; rs = sa + sb + cv; ec = (r > 15);
            end else begin
                r = av - bv - cv; rs = sa - sb - cv; ec = (r >= 0);
            end
            es = 4'(r & 15);
            eo = (rs > 7) || (rs < -8);
            ez = (es == 4'd0);
            checks++; if (g1 !== 5) begin errors++; $display("FAIL ex_lat_d1 a=%0d b=%0d got=%0d exp=5", av, bv, g1); end
            checks++; if (g2 !== 3) begin errors++; $display("FAIL ex_lat_d2 a=%0d b=%0d got=%0d exp=3", av, bv, g2); end
            checks++; if (g4 !== 2) begin errors++; $display("FAIL ex_lat_d4 a=%0d b=%0d got=%0d exp=2", av, bv, g4); end
            checks++; if (sw1 !== es) begin errors++; $display("FAIL ex_s_d1 a=%0d b=%0d ci=%0d sub=%0d got=%h exp=%h", av, bv, cv, sv, sw1, es); end
            checks++; if (sw2 !== es) begin errors++; $display("FAIL ex_s_d2 a=%0d b=%0d ci=%0d sub=%0d got=%h exp=%h", av, bv, cv, sv, sw2, es); end
            checks++; if (sw4 !== es) begin errors++; $display("FAIL ex_s_d4 a=%0d b=%0d ci=%0d sub=%0d got=%h exp=%h", av, bv, cv, sv, sw4, es); end
            checks++; if (cw1 !== ec) begin errors++; $display("FAIL ex_co_d1 a=%0d b=%0d ci=%0d sub=%0d got=%b exp=%b", av, bv, cv, sv, cw1, ec); end
            checks++; if (cw2 !== ec) begin errors++; $display("FAIL ex_co_d2 a=%0d b=%0d ci=%0d sub=%0d got=%b exp=%b", av, bv, cv, sv, cw2, ec); end
            checks++; if (cw4 !== ec) begin errors++; $display("FAIL ex_co_d4 a=%0d b=%0d ci=%0d sub=%0d got=%b exp=%b", av, bv, cv, sv, cw4, ec); end
            checks++; if (ow1 !== eo) begin errors++; $display("FAIL ex_ov_d1 a=%0d b=%0d ci=%0d sub=%0d got=%b exp=%b", av, bv, cv, sv, ow1, eo); end
            checks++; if (ow2 !== eo) begin errors++; $display("FAIL ex_ov_d2 a=%0d b=%0d ci=%0d sub=%0d got=%b exp=%b", av, bv, cv, sv, ow2, eo); end
            checks++; if (ow4 !== eo) begin errors++; $display("FAIL ex_ov_d4 a=%0d b=%0d ci=%0d sub=%0d got=%b exp=%b", av, bv, cv, sv, ow4, eo); end
            checks++; if (zw1 !== ez) begin errors++; $display("FAIL ex_zero_d1 a=%0d b=%0d ci=%0d sub=%0d got=%b exp=%b", av, bv, cv, sv, zw1, ez); end
            checks++; if (zw2 !== ez) begin errors++; $display("FAIL ex_zero_d2 a=%0d b=%0d ci=%0d sub=%0d got=%b exp=%b", av, bv, cv, sv, zw2, ez); end
            checks++; if (zw4 !== ez) begin errors++; $display("FAIL ex_zero_d4 a=%0d b=%0d ci=%0d sub=%0d got=%b exp=%b", av, bv, cv, sv, zw4, ez); end
        end
    endtask

    initial begin
        test_reset();
        test_bit_serial_add();
        test_digit4_flags();
        test_subtract();
        test_back_to_back();
        test_reset_midop();
        test_exhaustive_w4();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/serial_adder.md
# serial_adder

Parametrised multi-cycle adder/subtractor for the CPU datapath. It adds two WIDTH-bit operands DIGIT bits per clock, LSB digit first, with a start/busy/done handshake, and reports carry, signed overflow and zero flags. It is the sequential, width-generic successor to the single-bit full adder. It lets the ALU trade latency for area: DIGIT = 1 gives a bit-serial adder; DIGIT = WIDTH gives a single-cycle registered adder.

## Interface
- WIDTH, 16: operand/result width; must be ≥ 1.
- DIGIT, 1: bits processed per cycle; WIDTH % DIGIT must be 0, otherwise elaboration fails.
- clk  in  1  clock; all state changes on the rising edge.
- n_reset  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE or DONE.
- a  in  WIDTH  operand A, captured on the accepted start.
- b  in  WIDTH  operand B, captured on the accepted start.
- ci  in  1  carry-in (borrow-in when sub = 1), captured on the accepted start.
- sub  in  1  0 = a + b + ci; 1 = a − b − ci; captured on the accepted start.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse; results are valid from this cycle on.
- s  out  WIDTH  sum/difference; held until the next accepted start.
- co  out  1  carry out of the MSB; in sub mode, 1 = no borrow.
- ov  out  1  two's-complement signed overflow.
- zero  out  1  s == 0.

## Operation
- States:
  - IDLE (reset state).
  - RUN: counter steps 0..N−1, where N = WIDTH/DIGIT.
  - DONE: exactly one cycle.
- IDLE, start = 1 → RUN. On this edge:
  - Latch a; latch b ^ {WIDTH{sub}}.
  - Latch carry = ci ^ sub.
  - Clear the counter and result register.
- RUN, each edge: add the current digits of A and B' plus the carry register.
  - The DIGIT sum bits are written into the result at digit position = counter.
  - The carry register takes the digit carry-out.
  - The counter increments.
- RUN at counter = N−1 → DONE.
  - s, co and ov update on this edge.
  - ov = carry into MSB XOR carry out of MSB.
  - zero is computed from the final s.
- DONE, start = 0 → IDLE; outputs held.
- DONE, start = 1 → RUN. This is a back-to-back operation, handled the same as the IDLE start.
- start during RUN is ignored; captured operands are unaffected by input changes.
- busy = (state == RUN); done = (state == DONE).
- Reset (async, any state, including mid-RUN) takes effect immediately:
  - state = IDLE; counter = 0; carry = 0.
  - s = 0, co = 0, ov = 0, zero = 1; busy = 0, done = 0.
  - A partially computed result is discarded.
- Arithmetic is modulo 2^WIDTH; no saturation.

## Timing
- Start accepted at edge T0 → busy = 1 after T0.
- done = 1 and s/co/ov/zero are valid after edge T0+N; busy falls on the same edge.
- Latency is N cycles from start to done; throughput is one operation per N+1 cycles.
- Outputs are registered and never change except on done or reset.
- DIGIT = WIDTH → N = 1: RUN lasts one cycle; done follows start by one cycle.

## Structure
- Shared package (adder_pkg):
  - State enum: IDLE / RUN / DONE, with 2-bit encoding 00 / 01 / 10.
  - A clog2-based counter width function, with minimum width 1.
- Sub-module digit_adder #(DIGIT): purely combinational, a ripple of DIGIT instances of the team's full_adder cell.
  - Inputs: x, y (DIGIT bits each), cin.
  - Outputs: sum (DIGIT bits), cout, and c_msb (carry into the top bit, used for ov).
- Top level holds: FSM, counter, operand shift/index logic, carry register, result register, flags.

## Test plan
- WIDTH=16, DIGIT=1: a=0x1234, b=0x0FFF, ci=0, sub=0.
  - Required: s=0x2233, co=0, ov=0, zero=0.
  - done comes exactly 16 cycles after start; busy is high for 16 cycles.
- WIDTH=16, DIGIT=4: a=0x7FFF, b=0x0001, sub=0.
  - Required: s=0x8000, ov=1, co=0, done after 4 cycles.
  - Then a=0xFFFF, b=0x0001: s=0x0000, co=1, zero=1, ov=0.
- Subtraction, WIDTH=16, DIGIT=2:
  - a=5, b=7, sub=1, ci=0 → s=0xFFFE, co=0.
  - a=7, b=5, ci=1 → s=0x0001, co=1.
- Handshake:
  - start held high through RUN → no restart, operands unchanged.
  - start=1 in the DONE cycle → immediate new RUN; busy low only during DONE.
- Reset mid-op: deassert n_reset at counter=5 (DIGIT=1) with no clock edge present.
  - Required: outputs go to their reset values immediately.
  - After release, a fresh a=1, b=1 gives s=2.
- Exhaustive: WIDTH=4, DIGIT ∈ {1,2,4}, all a, b, ci, sub combinations.
  - Check s, co, ov, zero against a behavioural model.
